// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - serializes scalar and per-lane vector loads/stores onto a single-port data memory
module vector_mem_sequencer #(
    parameter int THREADS = 4,
    parameter int WORD_W  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      memREN,
    input  logic                      memWEN,
    input  logic                      isVector,
    input  logic                      halt,
    input  logic [THREADS-1:0]        vmask,
    input  logic [WORD_W-1:0]         saddr,
    input  logic [WORD_W-1:0]         sstore,
    input  logic [THREADS*WORD_W-1:0] vaddr,
    input  logic [THREADS*WORD_W-1:0] vstore,
    input  logic                      dhit,
    input  logic [WORD_W-1:0]         dmemload,
    output logic                      dmemREN,
    output logic                      dmemWEN,
    output logic [WORD_W-1:0]         dmemaddr,
    output logic [WORD_W-1:0]         dmemstore,
    output logic [WORD_W-1:0]         sload,
    output logic [THREADS*WORD_W-1:0] vload,
    output logic                      mem_stall,
    output logic                      done
);

    localparam int LANE_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(THREADS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state, next_state;
    logic [LANE_W-1:0]         lane;
    logic                      lat_vec;
    logic                      lat_wr;
    logic [THREADS-1:0]        lat_mask;
    logic [WORD_W-1:0]         lat_saddr;
    logic [WORD_W-1:0]         lat_sstore;
    logic [THREADS*WORD_W-1:0] lat_vaddr;
    logic [THREADS*WORD_W-1:0] lat_vstore;

    logic              req;
    logic              lane_active;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_store;
    logic              step;
    logic              capture;

    assign req         = (memREN | memWEN) & ~halt;
    assign lane_active = lat_vec ? lat_mask[lane] : 1'b1;
    assign cur_addr    = lat_vec ? lat_vaddr[int'(lane)*WORD_W +: WORD_W] : lat_saddr;
    assign cur_store   = lat_vec ? lat_vstore[int'(lane)*WORD_W +: WORD_W] : lat_sstore;
    assign done        = (state == DONE);

    // A masked-off lane still consumes one cycle slot but never strobes memory.
    always_comb begin
        next_state = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        mem_stall  = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_stall  = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (lane_active) begin
                    dmemREN   = ~lat_wr;
                    dmemWEN   = lat_wr;
                    dmemaddr  = cur_addr & ~WORD_W'(3);
                    dmemstore = cur_store;
                    step      = dhit;
                    capture   = dhit & ~lat_wr;
                end else begin
                    step = 1'b1;
                end
                if (step && (!lat_vec || lane == LAST_LANE)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            lane       <= '0;
            lat_vec    <= 1'b0;
            lat_wr     <= 1'b0;
            lat_mask   <= '0;
            lat_saddr  <= '0;
            lat_sstore <= '0;
            lat_vaddr  <= '0;
            lat_vstore <= '0;
            sload      <= '0;
            vload      <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                lat_vec    <= isVector;
                lat_wr     <= memWEN;
                lat_mask   <= vmask;
                lat_saddr  <= saddr;
                lat_sstore <= sstore;
                lat_vaddr  <= vaddr;
                lat_vstore <= vstore;
                lane       <= '0;
            end
            if (state == ACCESS && step && lat_vec && lane != LAST_LANE) begin
                lane <= lane + 1'b1;
            end
            if (capture) begin
                if (lat_vec) begin
                    vload[int'(lane)*WORD_W +: WORD_W] <= dmemload;
                end else begin
                    sload <= dmemload;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - self-checking bench for vector_mem_sequencer
module tb_vector_mem_sequencer;

    localparam int T = 4;
    localparam logic [31:0] KEY = 32'hDEADBFEB;

    logic         CLK = 1'b0;
    logic         RST, memREN, memWEN, isVector, halt, dhit;
    logic [T-1:0] vmask;
    logic [31:0]  saddr, sstore, dmemload;
    logic [T*32-1:0] vaddr, vstore;
    logic         dmemREN, dmemWEN, mem_stall, done;
    logic [31:0]  dmemaddr, dmemstore, sload;
    logic [T*32-1:0] vload;

    vector_mem_sequencer #(.THREADS(T), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .memREN(memREN), .memWEN(memWEN), .isVector(isVector),
        .halt(halt), .vmask(vmask), .saddr(saddr), .sstore(sstore), .vaddr(vaddr),
        .vstore(vstore), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .sload(sload),
        .vload(vload), .mem_stall(mem_stall), .done(done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int dly[T];
    logic [31:0] salt;
    bit   rand_halt;
    logic [31:0] m_sload;
    logic [31:0] m_vload[T];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lane;
    } acc_t;

    typedef struct {
        string       nm;
        bit          v, rn, wn;
        logic [3:0]  mk;
        logic [31:0] sa, base, stride;
        int          stall_idx, stall_n;
        int          exp_cycles, exp_acc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sload = '0;
        for (int i = 0; i < T; i++) m_vload[i] = '0;
    endtask

    // Plays one core instruction from acceptance to retirement, acting as memory.
    task automatic run_op(input bit v, input bit rn, input bit wn, input logic [3:0] mk,
                          input logic [31:0] sa, input logic [31:0] ss,
                          input logic [T*32-1:0] va, input logic [T*32-1:0] vs,
                          output int cycles, output int nacc);
        acc_t q[$];
        acc_t a;
        int   cyc, j, wd;
        bit   got_done;
        if (!v) q.push_back('{wn, sa & ~32'd3, ss, -1});
        else for (int i = 0; i < T; i++)
            if (mk[i]) q.push_back('{wn, va[i*32 +: 32] & ~32'd3, vs[i*32 +: 32], i});
        nacc = q.size();
        memREN = rn; memWEN = wn; isVector = v; vmask = mk;
        saddr = sa; sstore = ss; vaddr = va; vstore = vs; halt = 1'b0; dhit = 1'b0;
        #1 chk("accept_stall", {63'd0, mem_stall}, 64'd1);
        cyc = 1; j = 0; wd = dly[0]; got_done = 0;
        while (cyc < 200) begin
            @(negedge CLK);
            cyc++;
            dhit = 1'b0;
            dmemload = $urandom;
            if (done) begin
                chk("done_stall_low", {63'd0, mem_stall}, 64'd0);
                chk("pending_accesses", 64'(q.size()), 64'd0);
                memREN = 1'b0; memWEN = 1'b0; halt = 1'b0;
                got_done = 1;
                break;
            end
            chk("stall_in_access", {63'd0, mem_stall}, 64'd1);
            halt = rand_halt ? 1'($urandom % 2) : 1'b0;
            saddr = $urandom; sstore = $urandom; vmask = 4'($urandom); isVector = 1'($urandom);
            vaddr = {$urandom, $urandom, $urandom, $urandom};
            vstore = {$urandom, $urandom, $urandom, $urandom};
            if (dmemREN | dmemWEN) begin
                if (q.size() == 0) begin
                    chk("extra_strobe", 64'd1, 64'd0);
                end else begin
                    a = q[0];
                    chk("strobe_addr", {30'd0, dmemWEN, dmemREN, dmemaddr}, {30'd0, a.wr, !a.wr, a.addr});
                    if (a.wr) chk("store_data", {32'd0, dmemstore}, {32'd0, a.data});
                    if (wd == 0) begin
                        dhit = 1'b1;
                        dmemload = a.addr ^ KEY ^ salt;
                        if (!a.wr) begin
                            if (a.lane < 0) m_sload = dmemload;
                            else m_vload[a.lane] = dmemload;
                        end
                        void'(q.pop_front());
                        j++;
                        wd = (j < T) ? dly[j] : 0;
                    end else begin
                        wd--;
                    end
                end
            end else begin
                dhit = 1'($urandom % 2);
            end
        end
        if (!got_done) begin
            chk("done_timeout", 64'd0, 64'd1);
            memREN = 1'b0; memWEN = 1'b0; halt = 1'b0;
        end
        cycles = cyc;
        @(negedge CLK);
        dhit = 1'b0;
        chk("done_pulse_once", {62'd0, done, mem_stall}, 64'd0);
        chk("sload", {32'd0, sload}, {32'd0, m_sload});
        for (int i = 0; i < T; i++) chk("vload_lane", {32'd0, vload[i*32 +: 32]}, {32'd0, m_vload[i]});
    endtask

    vec_t tbl[8];
    int   cyc_o, acc_o, exp_c;
    logic [T*32-1:0] va, vs;

    initial begin
        tbl[0] = '{"lw_104",       0, 1, 0, 4'b0000, 32'h104, 32'h0,  32'h0,  -1, 0, 3,  1};
        tbl[1] = '{"vlw_all",      1, 1, 0, 4'b1111, 32'h0,   32'h0,  32'h10, -1, 0, 6,  4};
        tbl[2] = '{"vsw_0101",     1, 0, 1, 4'b0101, 32'h0,   32'h40, 32'h4,  -1, 0, 6,  2};
        tbl[3] = '{"sw_unaligned", 0, 0, 1, 4'b0000, 32'h107, 32'h0,  32'h0,  -1, 0, 3,  1};
        tbl[4] = '{"vlw_none",     1, 1, 0, 4'b0000, 32'h0,   32'h80, 32'h4,  -1, 0, 6,  0};
        tbl[5] = '{"rw_both",      0, 1, 1, 4'b0000, 32'h200, 32'h0,  32'h0,  -1, 0, 3,  1};
        tbl[6] = '{"vlw_stall_l1", 1, 1, 0, 4'b1111, 32'h0,   32'h80, 32'h8,   1, 5, 11, 4};
        tbl[7] = '{"vsw_1000_st2", 1, 0, 1, 4'b1000, 32'h0,   32'hC0, 32'h4,   0, 2, 8,  1};

        RST = 1'b1; memREN = 0; memWEN = 0; isVector = 0; halt = 0; dhit = 0;
        vmask = '0; saddr = '0; sstore = '0; vaddr = '0; vstore = '0; dmemload = '0;
        salt = '0; rand_halt = 0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {28'd0, dmemREN, dmemWEN, mem_stall, done, dmemaddr}, 64'd0);
        chk("reset_loads", {31'd0, |vload, sload}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < T; i++) dly[i] = 0;
            if (tbl[k].stall_idx >= 0) dly[tbl[k].stall_idx] = tbl[k].stall_n;
            for (int i = 0; i < T; i++) va[i*32 +: 32] = tbl[k].base + tbl[k].stride * i;
            vs = {$urandom, $urandom, $urandom, $urandom};
            run_op(tbl[k].v, tbl[k].rn, tbl[k].wn, tbl[k].mk, tbl[k].sa, $urandom, va, vs, cyc_o, acc_o);
            chk({tbl[k].nm, "_cycles"}, 64'(cyc_o), 64'(tbl[k].exp_cycles));
            chk({tbl[k].nm, "_accesses"}, 64'(acc_o), 64'(tbl[k].exp_acc));
            if (k == 0) chk("lw_104_value", {32'd0, sload}, {32'd0, 32'hDEADBEEF});
        end

        // halt blocks acceptance in IDLE
        halt = 1'b1; memWEN = 1'b1; saddr = 32'h300;
        #1 chk("halt_no_stall", {63'd0, mem_stall}, 64'd0);
        repeat (3) begin
            @(negedge CLK);
            chk("halt_idle", {60'd0, dmemREN, dmemWEN, done, mem_stall}, 64'd0);
        end
        halt = 1'b0; memWEN = 1'b0;
        @(negedge CLK);

        // reset while the vector op is on lane 2
        for (int i = 0; i < T; i++) va[i*32 +: 32] = 32'h100 * (i + 1);
        memREN = 1'b1; isVector = 1'b1; vmask = 4'b1111; vaddr = va;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            dhit = 1'b0;
            if (dmemREN && dmemaddr == va[2*32 +: 32]) break;
            if (dmemREN) dhit = 1'b1;
        end
        chk("rst_reached_lane2", {31'd0, dmemREN, dmemaddr}, {31'd0, 1'b1, va[2*32 +: 32]});
        RST = 1'b1; memREN = 1'b0; dhit = 1'b1;
        @(negedge CLK);
        chk("rst_abort", {60'd0, dmemREN, dmemWEN, done, mem_stall}, 64'd0);
        chk("rst_clears_loads", {31'd0, |vload, sload}, 64'd0);
        RST = 1'b0; dhit = 1'b0;
        model_reset();
        @(negedge CLK);
        for (int i = 0; i < T; i++) dly[i] = 0;
        run_op(0, 1, 0, 4'b0, 32'h208, 32'h0, '0, '0, cyc_o, acc_o);
        chk("post_rst_lw_cycles", 64'(cyc_o), 64'd3);

        // randomized operations against the access-list model
        rand_halt = 1;
        for (int n = 0; n < 40; n++) begin
            bit v, rn, wn;
            int kind, na;
            logic [3:0] mk;
            logic [31:0] base, stride;
            v = 1'($urandom);
            kind = int'($urandom % 3);
            rn = (kind != 1);
            wn = (kind != 0);
            mk = 4'($urandom);
            base = $urandom;
            stride = 32'($urandom_range(0, 16)) * 4;
            salt = $urandom;
            for (int i = 0; i < T; i++) begin
                dly[i] = int'($urandom % 4);
                va[i*32 +: 32] = base + stride * i;
            end
            vs = {$urandom, $urandom, $urandom, $urandom};
            na = v ? $countones(mk) : 1;
            exp_c = 2 + (v ? T : 1);
            for (int i = 0; i < na; i++) exp_c += dly[i];
            run_op(v, rn, wn, mk, $urandom, $urandom, va, vs, cyc_o, acc_o);
            chk("rand_cycles", 64'(cyc_o), 64'(exp_c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
